// File: rtl/plab4_net_router_output_credit_sched.sv
// Output-port scheduler: round-robin grant over three requesters, gated by a
// downstream credit count. Optional epoch partitioning via PLAB4_NET_OUTPUT_SCHED_EPOCH_EN.
module plab4_net_router_output_credit_sched #(
    parameter int p_num_free_nbits = 3,
    parameter int p_max_credits    = 4,
    parameter int p_epoch_len      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  reqs,
    input  logic [2:0]                  req_domain,
    output logic [2:0]                  grants,
    output logic                        out_val,
    input  logic                        out_rdy,
    input  logic                        credit_ret,
    output logic [p_num_free_nbits-1:0] num_free,
    output logic                        cur_domain
);

    localparam logic [p_num_free_nbits-1:0] MAX_CRED = p_num_free_nbits'(p_max_credits);

    logic [1:0]                  r_ptr;
    logic [p_num_free_nbits-1:0] r_num_free;
    logic [2:0]                  w_elig;
    logic [3:0]                  w_elig_pad;
    logic [2:0]                  w_grants;
    logic [1:0]                  w_win;
    logic [1:0]                  w_idx;
    logic                        w_found;
    logic                        w_can_send;
    logic                        w_fire;

`ifdef PLAB4_NET_OUTPUT_SCHED_EPOCH_EN
    localparam int EC_W = (p_epoch_len > 1) ? $clog2(p_epoch_len) : 1;

    logic [EC_W-1:0] r_ec;
    logic            r_cur_domain;

    // Epoch advances every cycle regardless of traffic so timing never leaks across domains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ec         <= '0;
            r_cur_domain <= 1'b0;
        end else if (r_ec == EC_W'(p_epoch_len - 1)) begin
            r_ec         <= '0;
            r_cur_domain <= ~r_cur_domain;
        end else begin
            r_ec <= r_ec + 1'b1;
        end
    end

    assign w_elig     = reqs & ~(req_domain ^ {3{r_cur_domain}});
    assign cur_domain = r_cur_domain;
`else
    logic w_unused_domain;

    assign w_unused_domain = ^req_domain;
    assign w_elig          = reqs;
    assign cur_domain      = 1'b0;
`endif

    assign w_elig_pad = {1'b0, w_elig};

    // First eligible index at or after ptr, wrapping 2 -> 0
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = r_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!w_found && w_elig_pad[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
            w_idx = (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
        end
    end

    assign w_can_send = out_rdy & (r_num_free != '0);
    assign w_grants   = (!reset && w_can_send && w_found) ? (3'b001 << w_win) : 3'b000;
    assign w_fire     = |w_grants;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 2'd0;
        end else if (w_fire) begin
            r_ptr <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
        end
    end

    // Returns arriving at full credit with no fire are dropped (saturation)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_free <= MAX_CRED;
        end else if (w_fire && !credit_ret) begin
            r_num_free <= r_num_free - 1'b1;
        end else if (!w_fire && credit_ret && (r_num_free != MAX_CRED)) begin
            r_num_free <= r_num_free + 1'b1;
        end
    end

    assign grants   = w_grants;
    assign out_val  = w_fire;
    assign num_free = r_num_free;

endmodule

// File: tb/tb_plab4_net_router_output_credit_sched.sv
// Scoreboard bench: driver pushes model expectations per cycle, monitor pops
// and compares on the falling edge. Epoch checks follow PLAB4_NET_OUTPUT_SCHED_EPOCH_EN.
module tb_plab4_net_router_output_credit_sched;

    localparam int NB  = 3;
    localparam int MAX = 4;
    localparam int LEN = 8;
`ifdef PLAB4_NET_OUTPUT_SCHED_EPOCH_EN
    localparam bit EPOCH = 1'b1;
`else
    localparam bit EPOCH = 1'b0;
`endif

    typedef struct {
        logic [2:0] grants;
        int         num_free;
        logic       dom;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    reqs, req_domain, grants;
    logic          out_val, out_rdy, credit_ret, cur_domain;
    logic [NB-1:0] num_free;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state: credits, priority pointer, edges since reset
    int m_cred, m_ptr, m_cyc;

    plab4_net_router_output_credit_sched #(
        .p_num_free_nbits(NB), .p_max_credits(MAX), .p_epoch_len(LEN)
    ) dut (
        .clk(clk), .reset(reset), .reqs(reqs), .req_domain(req_domain),
        .grants(grants), .out_val(out_val), .out_rdy(out_rdy),
        .credit_ret(credit_ret), .num_free(num_free), .cur_domain(cur_domain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cred = MAX;
        m_ptr  = 0;
        m_cyc  = 0;
    endtask

    // One cycle: drive inputs, record what the model says the DUT must show,
    // then advance the model across the coming edge.
    task automatic step(input logic [2:0] r, input logic [2:0] d, input logic rdy, input logic ret);
        exp_t e;
        int   dom, win;
        bit   fire;
        reqs = r; req_domain = d; out_rdy = rdy; credit_ret = ret;
        dom = EPOCH ? (m_cyc / LEN) % 2 : 0;
        win = -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (win < 0 && r[i] && (!EPOCH || d[i] == dom[0])) win = i;
        end
        fire = rdy && m_cred > 0 && win >= 0;
        e.grants   = fire ? 3'(1 << win) : 3'b000;
        e.num_free = m_cred;
        e.dom      = dom[0];
        exp_q.push_back(e);
        if (fire && !ret) m_cred--;
        else if (!fire && ret && m_cred < MAX) m_cred++;
        if (fire) m_ptr = (win + 1) % 3;
        m_cyc++;
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grants",     int'(grants),     int'(e.grants));
                chk("out_val",    int'(out_val),    int'(|e.grants));
                chk("num_free",   int'(num_free),   e.num_free);
                chk("cur_domain", int'(cur_domain), int'(e.dom));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grants", int'(grants), 0);
        chk("rst_num_free", int'(num_free), MAX);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin : driver
        reqs = 3'b111; req_domain = 3'b000; out_rdy = 1'b1; credit_ret = 1'b0;
        do_reset();

        // Idle, then round-robin sweep with all three requesting
        step(3'b000, 3'b000, 1'b1, 1'b0);
        repeat (3) step(3'b111, 3'b000, 1'b1, 1'b0);
        // Exhaust credits, stall, one return, one more fire
        step(3'b111, 3'b000, 1'b1, 1'b0);
        step(3'b111, 3'b000, 1'b1, 1'b0);
        step(3'b000, 3'b000, 1'b1, 1'b1);
        step(3'b111, 3'b000, 1'b1, 1'b0);
        step(3'b000, 3'b000, 1'b1, 1'b0);
        // Refill past the limit to exercise saturation
        repeat (6) step(3'b000, 3'b000, 1'b1, 1'b1);
        // Fire and return together at 2 credits
        repeat (2) step(3'b001, 3'b000, 1'b1, 1'b0);
        step(3'b010, 3'b000, 1'b1, 1'b1);
        // Back-pressure then release
        repeat (5) step(3'b010, 3'b000, 1'b0, 1'b0);
        step(3'b010, 3'b000, 1'b1, 1'b0);

        // Epoch partitioning: prev in domain 0, next in domain 1
        do_reset();
        repeat (2 * LEN + 2) step(3'b101, 3'b100, 1'b1, 1'b1);

        // Randomized traffic
        do_reset();
        repeat (400) begin
            step(3'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        // Mid-stream asynchronous reset with num_free = 1, ptr = 2
        do_reset();
        repeat (2) step(3'b111, 3'b000, 1'b1, 1'b0);
        step(3'b010, 3'b000, 1'b1, 1'b0);
        reqs = 3'b111; out_rdy = 1'b1; credit_ret = 1'b0;
        #2;
        chk("pre_rst_num_free", int'(num_free), 1);
        reset = 1'b1;
        #1;
        chk("async_grants",     int'(grants),     0);
        chk("async_out_val",    int'(out_val),    0);
        chk("async_num_free",   int'(num_free),   MAX);
        chk("async_cur_domain", int'(cur_domain), 0);
        #1;
        reset = 1'b0;
        model_reset();
        // ptr back at 0 shows up as grant 001 with all requesting
        step(3'b111, 3'b000, 1'b1, 1'b0);
        step(3'b000, 3'b000, 1'b1, 1'b0);

        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
